// File: rtl/projeto_pkg.sv
// Shared constants and types for the fetch stage and its neighbours.
package projeto_pkg;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // The only control state is whether the output register holds a live instruction.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: InstrMemory address/data, redirect request, and decode handshake.
interface instr_fetch_if;
    import projeto_pkg::*;

    logic [ADDR_W-1:0]  endereco;
    logic [INSTR_W-1:0] instrucao;
    logic               desvio_valido;
    logic [ADDR_W-1:0]  desvio_alvo;
    logic               saida_valida;
    logic               saida_pronta;
    logic [INSTR_W-1:0] saida_instrucao;
    logic [ADDR_W-1:0]  saida_pc;
    logic [ADDR_W-1:0]  saida_pc_mais4;
    logic               desalinhado;

    // Fetch stage side.
    modport master (
        output endereco, saida_valida, saida_instrucao, saida_pc, saida_pc_mais4, desalinhado,
        input  instrucao, desvio_valido, desvio_alvo, saida_pronta
    );

    // Memory/decode/branch-unit side.
    modport slave (
        input  endereco, saida_valida, saida_instrucao, saida_pc, saida_pc_mais4, desalinhado,
        output instrucao, desvio_valido, desvio_alvo, saida_pronta
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the pc, reads InstrMemory combinationally and registers
// {instruction, pc} toward decode with a valid/ready handshake and redirect flush.
module instr_fetch
    import projeto_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       PC_STEP  = INSTR_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    fetch_state_t       state, state_next;
    logic               valida;
    logic               load;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               desal_q;

    // Valid-bit state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Redirect always empties the stage; otherwise it is full after the edge
    // (either a new load or a held stall).
    always_comb begin
        state_next = state;
        if (bus.desvio_valido) state_next = EMPTY;
        else                   state_next = FULL;
    end

    // State decode to the handshake valid.
    always_comb begin
        valida = 1'b0;
        if (state == FULL) valida = 1'b1;
    end

    assign load = !valida || bus.saida_pronta;

    // pc and output registers; redirect outranks both load and stall, and keeps
    // the presented data so a same-cycle transfer to decode stays intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            instr_q <= '0;
            pc_q    <= '0;
            desal_q <= 1'b0;
        end else begin
            desal_q <= 1'b0;
            if (bus.desvio_valido) begin
                pc      <= {bus.desvio_alvo[ADDR_W-1:2], 2'b00};
                desal_q <= |bus.desvio_alvo[1:0];
            end else if (load) begin
                instr_q <= bus.instrucao;
                pc_q    <= pc;
                pc      <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    assign bus.endereco        = pc;
    assign bus.saida_valida    = valida;
    assign bus.saida_instrucao = instr_q;
    assign bus.saida_pc        = pc_q;
    assign bus.saida_pc_mais4  = pc_q + ADDR_W'(4);
    assign bus.desalinhado     = desal_q;
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage on the initiator side of the InstrMemory interface. Holds the program counter and drives `endereco` into InstrMemory. Captures the combinational `instrucao` returned in the same cycle and presents {instruction, pc} to decode through a registered valid/ready handshake. Supports stall (decode not ready) and redirect (branch/jump target), with a flush of the presented instruction.

Parameters:
RESET_PC, 32'h0000_0000, address fetched first after reset (must be 4-byte aligned)
PC_STEP, 4, byte increment per sequential fetch (fixed instruction size)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
endereco  output  32  address to InstrMemory; equals internal pc register
instrucao  input  32  instruction from InstrMemory, valid combinationally in the same cycle as endereco
desvio_valido  input  1  redirect request, sampled at clock edge
desvio_alvo  input  32  redirect target byte address
saida_valida  output  1  decode-side valid
saida_pronta  input  1  decode-side ready
saida_instrucao  output  32  registered instruction
saida_pc  output  32  registered address of saida_instrucao
saida_pc_mais4  output  32  saida_pc + 4 (combinational from register, wraps mod 2^32)
desalinhado  output  1  one-cycle pulse: last accepted redirect target had bits [1:0] != 0

Behaviour:
- Reset values:
  - pc = RESET_PC
  - saida_valida = 0
  - saida_instrucao = 0
  - saida_pc = 0
  - desalinhado = 0
  - endereco follows pc, so it is RESET_PC during reset.
- load = !saida_valida || saida_pronta.
- Priority at each edge:
  1. desvio_valido = 1: pc <= {desvio_alvo[31:2], 2'b00}; saida_valida <= 0; output data registers hold; desalinhado <= |desvio_alvo[1:0]. Redirect overrides both stall and load.
  2. Otherwise, load = 1: saida_instrucao <= instrucao; saida_pc <= pc; saida_valida <= 1; pc <= pc + PC_STEP.
  3. Otherwise (stall): pc, saida_* and saida_valida hold.
- desalinhado is 0 on every edge with no redirect.
- Handshake:
  - A transfer completes on an edge where saida_valida && saida_pronta.
  - While saida_valida = 1 and saida_pronta = 0, saida_instrucao and saida_pc are stable.
- Redirect and transfer in the same cycle: the transfer counts as completed (decode owns it); no new instruction is loaded; valid drops to 0.
- Latency:
  - The instruction at address A appears on saida one edge after pc = A.
  - After a redirect, one bubble cycle (valid = 0), then the target instruction.
- First edge after reset release: saida_valida = 1 with saida_pc = RESET_PC.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Reset asserted mid-operation: all outputs go to reset values asynchronously, without waiting for clk; fetch restarts at RESET_PC on the first edge after release.
- No internal FSM beyond the valid bit: states are EMPTY (valid = 0) and FULL (valid = 1).
  - EMPTY -> FULL on an edge with no redirect.
  - FULL -> FULL on transfer or stall.
  - Any -> EMPTY on redirect.

Decomposition:
- Shared package (projeto_pkg): RESET_PC_DEFAULT, INSTR_BYTES = 4, NOP_INSTR = 32'h0000_0013, ADDR_W = 32, INSTR_W = 32.
- No sub-module required; the pc register and output register live in one module.
- InstrMemory is instantiated alongside it in the bench and top level, not inside instr_fetch.

Test Plan:
1. Reset held 2 cycles, then released with ready = 1 and InstrMemory connected → during reset endereco = 0 and valid = 0; saida_pc then reads 0, 4, 8, 12, 16 on consecutive edges, and saida_instrucao matches InstrMemory contents at each address.
2. Stall: drop ready for 3 cycles while saida_pc = 8 → saida_pc stays 8, saida_instrucao is stable, endereco stays 12; raise ready → next edge saida_pc = 12.
3. Redirect: desvio_valido for 1 cycle with desvio_alvo = 32'h20 while saida_pc = 4 → next edge valid = 0 and endereco = 32'h20; following edge valid = 1, saida_pc = 32'h20, saida_pc_mais4 = 32'h24.
4. Redirect during stall (ready = 0, valid = 1) with desvio_alvo = 32'h40 → valid = 0 on the next edge; target fetched on the following edge.
5. Misaligned redirect with desvio_alvo = 32'h22 → endereco = 32'h20 and desalinhado = 1 for exactly one cycle.
6. Reset asserted between edges mid-run → valid = 0 and endereco = RESET_PC without a clock edge. Separately, with RESET_PC = 32'hFFFF_FFF8: saida_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
